// File: rtl/pueo_thresh_loader.sv
// Threshold loader for dual-beam DSP pairs: stages per-beam thresholds on a shared bus
// with one-hot CE strobes, then issues a common update pulse on commit (and once after reset).
module pueo_thresh_loader #(
  parameter int          NPAIR          = 24,
  parameter logic [17:0] DEFAULT_THRESH = 18'h3FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [7:0]           wr_addr_i,
  input  logic [17:0]          wr_data_i,
  input  logic                 commit_i,
  output logic [17:0]          thresh_o,
  output logic [2*NPAIR-1:0]   thresh_ce_o,
  output logic                 update_o,
  output logic                 init_done_o,
  output logic                 addr_err_o,
  output logic [15:0]          update_count_o
);

  localparam int NBEAM = 2 * NPAIR;
  localparam int IW    = $clog2(NBEAM + 1);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, UPD} state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [17:0]         thresh_q;
  logic [NBEAM-1:0]    ce_q;
  logic                update_q;
  logic                init_done_q;
  logic                addr_err_q;
  logic [15:0]         count_q;

  logic [NBEAM-1:0]    init_hot;
  logic [NBEAM-1:0]    wr_hot;
  logic                addr_ok;

  for (genvar gi = 0; gi < NBEAM; gi++) begin : g_hot
    assign init_hot[gi] = (idx_q == IW'(gi));
    assign wr_hot[gi]   = (wr_addr_i == 8'(gi));
  end

  assign addr_ok = (wr_addr_i < 8'(NBEAM));

  // Outputs are aligned with the state: INIT cycles carry a default strobe, WAIT carries
  // the last staged write (or nothing), UPD carries the update pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT;
      idx_q       <= '0;
      thresh_q    <= '0;
      ce_q        <= '0;
      update_q    <= 1'b0;
      init_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      ce_q     <= '0;
      update_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (idx_q == IW'(NBEAM)) begin
            state_q <= WAIT;
          end else begin
            ce_q     <= init_hot;
            thresh_q <= DEFAULT_THRESH;
            idx_q    <= idx_q + 1'b1;
          end
        end
        IDLE: begin
          if (wr_valid_i) begin
            if (addr_ok) begin
              ce_q     <= wr_hot;
              thresh_q <= wr_data_i;
            end else begin
              addr_err_q <= 1'b1;
            end
          end
          if (commit_i) state_q <= WAIT;
        end
        WAIT: begin
          update_q <= 1'b1;
          count_q  <= count_q + 16'd1;
          state_q  <= UPD;
        end
        UPD: begin
          init_done_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign wr_ready_o     = (state_q == IDLE);
  assign thresh_o       = thresh_q;
  assign thresh_ce_o    = ce_q;
  assign update_o       = update_q;
  assign init_done_o    = init_done_q;
  assign addr_err_o     = addr_err_q;
  assign update_count_o = count_q;

endmodule
